seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 186 ++++++++++++++++++
 tb/tb_seq_alu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus a bit-serial unsigned multiplier.
// Results and flags live in a registered flag/result bank updated only on completion.
module seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_hi,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_SHL = 4'd7;
    localparam logic [3:0] OP_SHR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     c_q, c_d, c_hi_q, c_hi_d;
    logic             carry_q, carry_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [2*W-1:0]   acc_q, acc_d, mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             cin_c;
    logic [W:0]       sum_c, diff_c, ssum_c, sdiff_c;
    logic [2*W-1:0]   acc_nxt_c;

    // Unsigned sums give carry/borrow; sign-extended sums give overflow.
    assign cin_c     = (op == OP_ADC || op == OP_SBC) ? carry_q : 1'b0;
    assign sum_c     = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin_c);
    assign diff_c    = (W+1)'(a) - (W+1)'(b) - (W+1)'(cin_c);
    assign ssum_c    = {a[W-1], a} + {b[W-1], b} + (W+1)'(cin_c);
    assign sdiff_c   = {a[W-1], a} - {b[W-1], b} - (W+1)'(cin_c);
    assign acc_nxt_c = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            c_q      <= '0;
            c_hi_q   <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            c_hi_q   <= c_hi_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        c_hi_d   = c_hi_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        state_d  = S_MUL;
                        acc_d    = '0;
                        mcand_d  = (2*W)'(a);
                        mplier_d = b;
                        cnt_d    = '0;
                    end else begin
                        done_d  = 1'b1;
                        c_hi_d  = '0;
                        carry_d = 1'b0;
                        ovf_d   = 1'b0;
                        case (op)
                            OP_ADD, OP_ADC: begin
                                c_d     = sum_c[W-1:0];
                                carry_d = sum_c[W];
                                ovf_d   = ssum_c[W] ^ ssum_c[W-1];
                            end
                            OP_SUB, OP_SBC: begin
                                c_d     = diff_c[W-1:0];
                                carry_d = diff_c[W];
                                ovf_d   = sdiff_c[W] ^ sdiff_c[W-1];
                            end
                            OP_AND: c_d = a & b;
                            OP_OR:  c_d = a | b;
                            OP_XOR: c_d = a ^ b;
                            OP_SHL: begin
                                c_d     = {a[W-2:0], carry_q};
                                carry_d = a[W-1];
                            end
                            OP_SHR: begin
                                c_d     = {carry_q, a[W-1:1]};
                                carry_d = a[0];
                            end
                            OP_CMP: begin
                                // Flags only; result registers keep their contents.
                                c_hi_d  = c_hi_q;
                                carry_d = diff_c[W];
                                ovf_d   = sdiff_c[W] ^ sdiff_c[W-1];
                            end
                            default: c_d = a;
                        endcase
                        if (op == OP_CMP) begin
                            zero_d = (diff_c[W-1:0] == '0);
                            neg_d  = diff_c[W-1];
                        end else begin
                            zero_d = (c_d == '0);
                            neg_d  = c_d[W-1];
                        end
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_nxt_c;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    c_d     = acc_nxt_c[W-1:0];
                    c_hi_d  = acc_nxt_c[2*W-1:W];
                    carry_d = (acc_nxt_c[2*W-1:W] != '0);
                    zero_d  = (acc_nxt_c == '0);
                    neg_d   = acc_nxt_c[2*W-1];
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign c     = c_q;
    assign c_hi  = c_hi_q;
    assign carry = carry_q;
    assign zero  = zero_q;
    assign neg   = neg_q;
    assign ovf   = ovf_q;
    assign done  = done_q;
    assign busy  = (state_q == S_MUL);

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver models each accepted op arithmetically and queues
// the expected result/completion cycle; a monitor checks outputs every cycle.
module tb_seq_alu;

    localparam int unsigned W = 8;
    localparam longint FULL = longint'(1) << W;
    localparam longint HALF = longint'(1) << (W - 1);
    localparam longint MASK = FULL - 1;

    localparam int OP_ADD = 0, OP_ADC = 1, OP_SUB = 2, OP_SBC = 3, OP_AND = 4, OP_OR = 5;
    localparam int OP_XOR = 6, OP_SHL = 7, OP_SHR = 8, OP_MUL = 9, OP_CMP = 10;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] c, c_hi;
    logic         carry, zero, neg, ovf, busy, done;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
        .c(c), .c_hi(c_hi), .carry(carry), .zero(zero), .neg(neg), .ovf(ovf),
        .busy(busy), .done(done)
    );

    typedef struct {
        int     cyc;
        longint c;
        longint c_hi;
        longint carry;
        longint zero;
        longint neg;
        longint ovf;
    } exp_t;

    exp_t   q[$];
    exp_t   last;
    int     cyc = 0;
    int     busy_lo = 0;
    int     busy_hi = -1;
    int     vectors = 0;
    int     miscompares = 0;
    longint rc = 0, rchi = 0, rcy = 0, rz = 0, rn = 0, rv = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic longint sgn(input longint v);
        return (v >= HALF) ? v - FULL : v;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.cyc = 0; e.c = 0; e.c_hi = 0; e.carry = 0; e.zero = 0; e.neg = 0; e.ovf = 0;
        return e;
    endfunction

    // Arithmetic reference model: update architectural state and queue the expectation.
    task automatic model(input int o, input longint x, input longint y);
        exp_t   e;
        longint cin, r, sr, res;
        cin = (o == OP_ADC || o == OP_SBC) ? rcy : 0;
        case (o)
            OP_ADD, OP_ADC: begin
                r = x + y + cin; sr = sgn(x) + sgn(y) + cin;
                rc = r & MASK; rchi = 0; rcy = (r >= FULL); rv = (sr >= HALF || sr < -HALF);
                rz = (rc == 0); rn = (rc >= HALF);
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                r = x - y - cin; sr = sgn(x) - sgn(y) - cin; res = r & MASK;
                rcy = (r < 0); rv = (sr >= HALF || sr < -HALF);
                rz = (res == 0); rn = (res >= HALF);
                if (o != OP_CMP) begin rc = res; rchi = 0; end
            end
            OP_MUL: begin
                r = x * y;
                rc = r & MASK; rchi = r >> W; rcy = (rchi != 0); rv = 0;
                rz = (r == 0); rn = (rchi >= HALF);
            end
            default: begin
                case (o)
                    OP_AND:  res = x & y;
                    OP_OR:   res = x | y;
                    OP_XOR:  res = x ^ y;
                    OP_SHL:  res = ((x << 1) | rcy) & MASK;
                    OP_SHR:  res = (x >> 1) | (rcy << (W - 1));
                    default: res = x;
                endcase
                if (o == OP_SHL) rcy = (x >= HALF);
                else if (o == OP_SHR) rcy = x & 1;
                else rcy = 0;
                rc = res; rchi = 0; rv = 0; rz = (rc == 0); rn = (rc >= HALF);
            end
        endcase
        e.c = rc; e.c_hi = rchi; e.carry = rcy; e.zero = rz; e.neg = rn; e.ovf = rv;
        if (o == OP_MUL) begin
            e.cyc   = cyc + 1 + int'(W);
            busy_lo = cyc + 1;
            busy_hi = cyc + int'(W);
        end else begin
            e.cyc = cyc + 1;
        end
        q.push_back(e);
    endtask

    task automatic issue(input int o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1; op = 4'(o); a = x; b = y;
        if (!(cyc >= busy_lo && cyc <= busy_hi)) model(o, longint'(x), longint'(y));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
        end
    endtask

    // Reset with start held high: the request must be dropped along with any MUL in flight.
    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; start = 1'b1; op = 4'(OP_ADD); a = W'($urandom); b = W'($urandom);
        q.delete(); busy_lo = 0; busy_hi = -1; last = zero_exp();
        rc = 0; rchi = 0; rcy = 0; rz = 0; rn = 0; rv = 0;
        @(negedge clk);
        resetn = 1'b1; start = 1'b0;
    endtask

    // Monitor: completion timing and full output state every cycle.
    initial begin
        exp_t e;
        last = zero_exp();
        forever begin
            @(posedge clk);
            #1;
            chk("busy", longint'(busy), longint'(cyc >= busy_lo && cyc <= busy_hi));
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", longint'(cyc), longint'(e.cyc));
                    last = e;
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                chk("done_missing", 0, 1);
                last = q.pop_front();
            end
            chk("c", longint'(c), last.c);
            chk("c_hi", longint'(c_hi), last.c_hi);
            chk("carry", longint'(carry), last.carry);
            chk("zero", longint'(zero), last.zero);
            chk("neg", longint'(neg), last.neg);
            chk("ovf", longint'(ovf), last.ovf);
        end
    end

    initial begin
        int o, guard;
        do_reset();
        idle(1);
        // Directed scenarios from the worked examples.
        issue(OP_ADD, 8'hFF, 8'h01);
        issue(OP_ADC, 8'h10, 8'h20);
        issue(OP_ADD, 8'h7F, 8'h01);
        issue(OP_SUB, 8'h05, 8'h06);
        issue(OP_CMP, 8'h06, 8'h06);
        idle(1);
        issue(OP_MUL, 8'hFF, 8'hFF);
        idle(3);
        issue(OP_ADD, 8'h01, 8'h02);
        idle(8);
        issue(OP_ADD, 8'hFF, 8'h01);
        issue(OP_SHL, 8'h81, 8'h00);
        issue(OP_SUB, 8'h06, 8'h05);
        issue(OP_SHR, 8'h01, 8'h00);
        issue(OP_SBC, 8'h80, 8'h00);
        idle(1);
        issue(OP_MUL, 8'h12, 8'h34);
        idle(3);
        do_reset();
        idle(2);
        issue(OP_MUL, 8'h00, 8'h5A);
        idle(W + 1);
        // Randomized traffic including back-to-back, MUL overlap and occasional resets.
        for (int i = 0; i < 400; i++) begin
            o = int'($urandom_range(0, 15));
            issue(o, W'($urandom), W'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            if ($urandom_range(0, 59) == 0) do_reset();
        end
        idle(1);
        guard = 0;
        while (q.size() != 0 && guard < 40) begin
            idle(1);
            guard++;
        end
        chk("drain", longint'(q.size()), 0);
        idle(3);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
